d_sram_bridge: RTL and testbench

Data-side bridge between the CPU core's single-cycle SRAM-style data port and an SRAM-like handshake bus (req / addr_ok / data_ok). It sits directly downstream of the core's data-memory port, in front of the data cache or AXI adapter. It turns one CPU access into one bus transaction. It stalls the pipeline until the transaction completes.

---
 rtl/d_sram_bridge.sv | 113 +++++++++++
 tb/tb_d_sram_bridge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/d_sram_bridge.sv
// Bridges the CPU single-cycle data port onto an SRAM-like req/addr_ok/data_ok bus.
// Optional macro DSRAM_BRIDGE_BYPASS_EN forwards completing read data without a DONE cycle.
module d_sram_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_data_en,
  input  logic [3:0]  cpu_data_wen,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  input  logic        cpu_longest_stall,
  output logic        cpu_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state;
  state_t      finish_state;
  logic [31:0] rdata_q;
  logic [1:0]  size_dec;
  logic        accept;
  logic        complete;
  logic        bypass_hit;

  // Only the exact byte and half-word lane patterns shrink the access; everything else is a word.
  always_comb begin
    size_dec = 2'd2;
    case (cpu_data_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_dec = 2'd0;
      4'b0011, 4'b1100:                   size_dec = 2'd1;
      default:                            size_dec = 2'd2;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      S_IDLE: begin
        accept   = cpu_data_en & data_addr_ok;
        complete = accept & data_data_ok;
      end
      S_REQ: begin
        accept   = data_addr_ok;
        complete = data_addr_ok & data_data_ok;
      end
      S_WAIT:  complete = data_data_ok;
      default: ;
    endcase
  end

`ifdef DSRAM_BRIDGE_BYPASS_EN
  // A completion with no other stall source retires immediately, skipping DONE.
  assign bypass_hit   = complete & ~cpu_longest_stall;
  assign finish_state = cpu_longest_stall ? S_DONE : S_IDLE;
`else
  assign bypass_hit   = 1'b0;
  assign finish_state = S_DONE;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      rdata_q <= 32'd0;
    end else begin
      if (complete && !data_wr)
        rdata_q <= data_rdata;
      case (state)
        S_IDLE: begin
          if (complete)
            state <= finish_state;
          else if (accept)
            state <= S_WAIT;
          else if (cpu_data_en)
            state <= S_REQ;
        end
        S_REQ: begin
          if (complete)
            state <= finish_state;
          else if (accept)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (complete)
            state <= finish_state;
        end
        S_DONE: begin
          if (!cpu_longest_stall)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Control outputs are forced low while reset is asserted, even with the CPU requesting.
  assign data_req       = resetn & (((state == S_IDLE) & cpu_data_en) | (state == S_REQ));
  assign data_wr        = resetn & (|cpu_data_wen);
  assign data_size      = resetn ? size_dec : 2'd0;
  assign data_addr      = (size_dec == 2'd2) ? {cpu_data_addr[31:2], 2'b00} : cpu_data_addr;
  assign data_wdata     = cpu_data_wdata;
  assign cpu_stall      = resetn & cpu_data_en & (state != S_DONE) & ~bypass_hit;
  assign cpu_data_rdata = (resetn & bypass_hit) ? data_rdata : rdata_q;

endmodule

// File: tb/tb_d_sram_bridge.sv
// Directed self-checking bench for d_sram_bridge; honours DSRAM_BRIDGE_BYPASS_EN when defined.
module tb_d_sram_bridge;

`ifdef DSRAM_BRIDGE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        resetn;
  logic        cpu_data_en;
  logic [3:0]  cpu_data_wen;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        cpu_longest_stall;
  logic        cpu_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int check_count = 0;
  int error_count = 0;
  int stall_cycles;
  int req_cycles;

  d_sram_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .cpu_data_en       (cpu_data_en),
    .cpu_data_wen      (cpu_data_wen),
    .cpu_data_addr     (cpu_data_addr),
    .cpu_data_wdata    (cpu_data_wdata),
    .cpu_data_rdata    (cpu_data_rdata),
    .cpu_longest_stall (cpu_longest_stall),
    .cpu_stall         (cpu_stall),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .data_rdata        (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge and returns at the falling edge.
  task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic aok, input logic dok,
                               input logic [31:0] rdata, input logic longest);
    @(posedge clk);
    #1;
    cpu_data_en       = en;
    cpu_data_wen      = wen;
    cpu_data_addr     = addr;
    cpu_data_wdata    = wdata;
    data_addr_ok      = aok;
    data_data_ok      = dok;
    data_rdata        = rdata;
    cpu_longest_stall = longest;
    @(negedge clk);
  endtask

  // Runs one access with addr_ok/data_ok pulsed on the given cycle offsets from the en cycle.
  task automatic doAccess(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] rdata,
                          input int a_cyc, input int d_cyc, output int n_stall, output int n_req);
    bit done;
    done    = 1'b0;
    n_stall = 0;
    n_req   = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      applyStimulus(1'b1, wen, addr, 32'd0, (k == a_cyc), (k == d_cyc), rdata, 1'b0);
      if (data_req) n_req++;
      if (cpu_stall) n_stall++;
      else done = 1'b1;
    end
    if (!done) checkOutput("access_timeout", 32'd0, 32'd1);
    applyStimulus(1'b0, 4'b0000, addr, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    resetn            = 1'b0;
    cpu_data_en       = 1'b1;
    cpu_data_wen      = 4'b1111;
    cpu_data_addr     = 32'h0000_1006;
    cpu_data_wdata    = 32'd0;
    cpu_longest_stall = 1'b0;
    data_addr_ok      = 1'b0;
    data_data_ok      = 1'b0;
    data_rdata        = 32'd0;
    #3;
    checkOutput("reset_req",   {31'd0, data_req},  32'd0);
    checkOutput("reset_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("reset_wr",    {31'd0, data_wr},   32'd0);
    checkOutput("reset_size",  {30'd0, data_size}, 32'd0);
    checkOutput("reset_rdata", cpu_data_rdata,     32'd0);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    resetn = 1'b1;

    // Size decode for a half-word pattern and an irregular pattern.
    applyStimulus(1'b0, 4'b1100, 32'h0000_2003, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("half_size", {30'd0, data_size}, 32'd1);
    applyStimulus(1'b0, 4'b0101, 32'h0000_2003, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("odd_wen_size", {30'd0, data_size}, 32'd2);

    // Best-case word read.
    applyStimulus(1'b1, 4'b0000, 32'h0000_1006, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("rd_req",   {31'd0, data_req},  32'd1);
    checkOutput("rd_addr",  data_addr,          32'h0000_1004);
    checkOutput("rd_size",  {30'd0, data_size}, 32'd2);
    checkOutput("rd_wr",    {31'd0, data_wr},   32'd0);
    checkOutput("rd_stall", {31'd0, cpu_stall}, (BYP != 0) ? 32'd0 : 32'd1);
    checkOutput("rd_cycle0_rdata", cpu_data_rdata, (BYP != 0) ? 32'hDEAD_BEEF : 32'd0);
    applyStimulus(1'b0, 4'b0000, 32'h0000_1006, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd_done_rdata", cpu_data_rdata,     32'hDEAD_BEEF);
    checkOutput("rd_done_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("rd_done_req",   {31'd0, data_req},  32'd0);

    // Byte write: fields on the first cycle, then completion must not touch the read register.
    applyStimulus(1'b1, 4'b0100, 32'h1000_0002, 32'h00AB_0000, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("wr_req",   {31'd0, data_req},  32'd1);
    checkOutput("wr_wr",    {31'd0, data_wr},   32'd1);
    checkOutput("wr_size",  {30'd0, data_size}, 32'd0);
    checkOutput("wr_addr",  data_addr,          32'h1000_0002);
    checkOutput("wr_wdata", data_wdata,         32'h00AB_0000);
    checkOutput("wr_stall", {31'd0, cpu_stall}, 32'd1);
    applyStimulus(1'b1, 4'b0100, 32'h1000_0002, 32'h00AB_0000, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    checkOutput("wr_req_again", {31'd0, data_req}, 32'd1);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("wr_keeps_rdata", cpu_data_rdata, 32'hDEAD_BEEF);

    // addr_ok three cycles after en, data_ok two cycles after that.
    doAccess(4'b0000, 32'h0000_3000, 32'hCAFE_F00D, 3, 5, stall_cycles, req_cycles);
    checkOutput("slow_req_cycles",   req_cycles,   32'd4);
    checkOutput("slow_stall_cycles", stall_cycles, 32'(6 - BYP));
    checkOutput("slow_rdata",        cpu_data_rdata, 32'hCAFE_F00D);

    // Completion while another stall source is active, then three held DONE cycles.
    applyStimulus(1'b1, 4'b0000, 32'h0000_4000, 32'd0, 1'b1, 1'b1, 32'h0BAD_CAFE, 1'b1);
    checkOutput("hold_c0_stall", {31'd0, cpu_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b0000, 32'h0000_4000, 32'd0, 1'b1, 1'b1, 32'h1111_1111, 1'b1);
      checkOutput("hold_req",   {31'd0, data_req},  32'd0);
      checkOutput("hold_stall", {31'd0, cpu_stall}, 32'd0);
      checkOutput("hold_rdata", cpu_data_rdata,     32'h0BAD_CAFE);
    end
    applyStimulus(1'b1, 4'b0000, 32'h0000_4000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("hold_release_req",   {31'd0, data_req},  32'd0);
    checkOutput("hold_release_stall", {31'd0, cpu_stall}, 32'd0);
    applyStimulus(1'b1, 4'b0000, 32'h0000_5000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("after_hold_idle_req", {31'd0, data_req},  32'd1);
    checkOutput("after_hold_stall",    {31'd0, cpu_stall}, 32'd1);
    applyStimulus(1'b1, 4'b0000, 32'h0000_5000, 32'd0, 1'b1, 1'b1, 32'h2222_2222, 1'b0);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("after_hold_rdata", cpu_data_rdata, 32'h2222_2222);

    // Reset pulsed while in WAIT, then a stray data_ok in IDLE.
    applyStimulus(1'b1, 4'b0000, 32'h0000_6000, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 32'h0000_6000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("wait_req",   {31'd0, data_req},  32'd0);
    checkOutput("wait_stall", {31'd0, cpu_stall}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midrst_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("midrst_req",   {31'd0, data_req},  32'd0);
    checkOutput("midrst_rdata", cpu_data_rdata,     32'd0);
    cpu_data_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 32'h9999_9999, 1'b0);
    checkOutput("stray_rdata", cpu_data_rdata, 32'd0);
    checkOutput("stray_req",   {31'd0, data_req}, 32'd0);
    applyStimulus(1'b1, 4'b0000, 32'h0000_7000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("post_rst_idle_req", {31'd0, data_req}, 32'd1);
    applyStimulus(1'b1, 4'b0000, 32'h0000_7000, 32'd0, 1'b1, 1'b1, 32'h3333_3333, 1'b0);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("post_rst_rdata", cpu_data_rdata, 32'h3333_3333);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
